// File: rtl/mont_pkg.sv
// Shared constants, parameter-legality checks and a reference model for the
// word-level Montgomery reducer.
package mont_pkg;

    localparam int unsigned Q_DEFAULT = 3329;
    localparam int unsigned W_DEFAULT = 8;

    function automatic int unsigned qh_of(input int unsigned q, input int unsigned w);
        return (q - 1) >> w;
    endfunction

    // Q must have the shape QH*2^W + 1 for the single-word quotient trick.
    function automatic bit q_form_ok(input int unsigned q, input int unsigned w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        return (w > 0) && (w < 32) && (q > 1) && ((64'(q) & mask) == 64'd1);
    endfunction

    function automatic bit q_size_ok(input int unsigned q, input int unsigned w,
                                     input int unsigned w_in);
        if (w_in <= w + 1 || w_in > 63)
            return 1'b0;
        return 64'(q) < (64'd1 << (w_in - w - 1));
    endfunction

    // Worst-case growth through L iterations, starting from an all-ones input.
    function automatic bit bound_ok(input int unsigned q, input int unsigned w,
                                    input int unsigned l, input int unsigned w_in);
        longint unsigned b;
        longint unsigned qh;
        b  = (64'd1 << w_in) - 64'd1;
        qh = 64'(qh_of(q, w));
        for (int unsigned k = 0; k < l; k++)
            b = (b >> w) + qh * ((64'd1 << w) - 64'd1) + 64'd1;
        return b < 64'(2) * 64'(q);
    endfunction

    // c * 2^(-shift) mod q by repeated modular halving (q odd).
    function automatic longint unsigned mont_ref(input longint unsigned c,
                                                 input longint unsigned q,
                                                 input int unsigned shift);
        longint unsigned r;
        r = c % q;
        for (int unsigned i = 0; i < shift; i++)
            r = r[0] ? ((r + q) >> 1) : (r >> 1);
        return r;
    endfunction

endpackage

// File: rtl/mont_mac_stage.sv
// One combinational Montgomery word iteration: C' = X*QH + (C >> W) + (C_low != 0),
// with X = -C_low mod 2^W, so that C' == C * 2^(-W) mod Q.
module mont_mac_stage #(
    parameter int unsigned W_IN = 32,
    parameter int unsigned W    = 8,
    parameter int unsigned QH   = 13
) (
    input  logic [W_IN-1:0] c_in,
    output logic [W_IN-1:0] c_out
);

    localparam int unsigned PW = W + $clog2(QH);

    logic [W-1:0]  cl;
    logic [W-1:0]  x;
    logic          carry;
    logic [PW-1:0] prod;

    assign cl    = c_in[W-1:0];
    assign x     = '0 - cl;
    assign carry = |cl;
    // X < 2^W and QH <= 2^clog2(QH), so the product always fits in PW bits.
    assign prod  = PW'(x) * PW'(QH);
    assign c_out = W_IN'(prod) + (c_in >> W) + W_IN'(carry);

endmodule

// File: rtl/mont_red_pipe.sv
// Pipelined Montgomery reducer: L MAC stages plus a conditional-subtract stage,
// valid/ready streaming with bubble collapsing and a side-band tag.
module mont_red_pipe
    import mont_pkg::*;
#(
    parameter int unsigned W_IN  = 32,
    parameter int unsigned Q     = Q_DEFAULT,
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned L     = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_IN-1:0]      in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(Q)-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned QH    = qh_of(Q, W);
    localparam int unsigned OUT_W = $clog2(Q);

    if (!q_form_ok(Q, W)) begin : g_bad_q_form
        $error("mont_red_pipe: Q mod 2^W must equal 1");
    end
    if (!q_size_ok(Q, W, W_IN)) begin : g_bad_q_size
        $error("mont_red_pipe: Q must be below 2^(W_IN-W-1)");
    end
    if (!bound_ok(Q, W, L, W_IN)) begin : g_bad_bound
        $error("mont_red_pipe: L iterations do not bring C_L below 2Q");
    end

    logic [L+1:1]     v;
    logic [L+1:1]     cap;
    logic [L+1:1]     up_v;
    logic             full_tail;
    logic [W_IN-1:0]  c_q     [1:L];
    logic [W_IN-1:0]  mac_in  [1:L];
    logic [W_IN-1:0]  mac_out [1:L];
    logic [TAG_W-1:0] tag_q   [1:L+1];
    logic [TAG_W-1:0] up_tag  [1:L+1];
    logic [OUT_W-1:0] res_q;
    logic [W_IN:0]    diff;
    logic [W_IN-1:0]  res_full;
    logic             unused_res_hi;

    assign up_v         = {v[L:1], in_valid};
    assign up_tag[L+1]  = tag_q[L];

    for (genvar k = 1; k <= L; k++) begin : g_mac
        if (k == 1) begin : g_first
            assign mac_in[k] = in_data;
            assign up_tag[k] = in_tag;
        end else begin : g_rest
            assign mac_in[k] = c_q[k-1];
            assign up_tag[k] = tag_q[k-1];
        end

        mont_mac_stage #(
            .W_IN (W_IN),
            .W    (W),
            .QH   (QH)
        ) u_mac (
            .c_in  (mac_in[k]),
            .c_out (mac_out[k])
        );
    end

    // Stage i may capture unless it and every stage after it are full and
    // the output is stalled; expanded flat to keep the chain loop-free.
    always_comb begin
        cap       = '0;
        full_tail = 1'b1;
        for (int unsigned i = 1; i <= L + 1; i++) begin
            full_tail = 1'b1;
            for (int unsigned j = i; j <= L + 1; j++)
                full_tail = full_tail & v[j];
            cap[i] = out_ready | ~full_tail;
        end
    end

    assign diff          = {1'b0, c_q[L]} - (W_IN + 1)'(Q);
    assign res_full      = diff[W_IN] ? c_q[L] : diff[W_IN-1:0];
    assign unused_res_hi = ^res_full[W_IN-1:OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            res_q <= '0;
            for (int unsigned k = 1; k <= L; k++)
                c_q[k] <= '0;
            for (int unsigned k = 1; k <= L + 1; k++)
                tag_q[k] <= '0;
        end else begin
            for (int unsigned k = 1; k <= L + 1; k++) begin
                if (cap[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k])
                        tag_q[k] <= up_tag[k];
                end
            end
            for (int unsigned k = 1; k <= L; k++) begin
                if (cap[k] && up_v[k])
                    c_q[k] <= mac_out[k];
            end
            if (cap[L+1] && up_v[L+1])
                res_q <= res_full[OUT_W-1:0];
        end
    end

    assign in_ready  = cap[1];
    assign out_valid = v[L+1];
    assign out_data  = res_q;
    assign out_tag   = tag_q[L+1];

endmodule

// File: tb/tb_mont_red_pipe.sv
// Scoreboard bench for mont_red_pipe: default instance plus a Q=7681, W=9, L=3 instance.
module tb_mont_red_pipe;
    import mont_pkg::*;

    localparam int BOUND = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_tag, out_tag;
    logic [11:0] out_data;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_data2;
    logic [3:0]  in_tag2, out_tag2;
    logic [12:0] out_data2;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_d[$];
    logic [3:0]  exp_t[$];
    logic [12:0] exp2_d[$];
    logic [3:0]  exp2_t[$];

    always #5 clk = ~clk;

    mont_red_pipe #(.W_IN(32), .Q(3329), .W(8), .L(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    mont_red_pipe #(.W_IN(32), .Q(7681), .W(9), .L(3), .TAG_W(4)) dut_alt (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_tag(out_tag2)
    );

    function automatic logic [31:0] rand_c();
        if ($urandom_range(0, 3) == 0)
            return 32'($urandom_range(0, 20000));
        return $urandom;
    endfunction

    function automatic logic [11:0] ref1(input logic [31:0] c);
        return 12'(mont_ref(64'(c), 64'(3329), 32));
    endfunction

    function automatic logic [12:0] ref2(input logic [31:0] c);
        return 13'(mont_ref(64'(c), 64'(7681), 27));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 12'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        total++; if (out_tag !== 4'd0) begin bad++; $display("FAIL reset_out_tag got=%0d want=0", out_tag); end
    endtask

    task automatic test_single();
        logic [31:0] c_tab [5] = '{32'd0, 32'd1, 32'd256, 32'd3329, 32'hFFFF_FFFF};
        logic [11:0] r_tab [5] = '{12'd0, 12'd1929, 12'd1132, 12'd0, 12'd1401};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = c_tab[i]; in_tag = 4'(i + 3);
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_accept[%0d] got=%b want=1", i, in_ready); end
            @(posedge clk); #1 in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (out_valid !== 1'b1 && lat < BOUND) begin @(negedge clk); lat++; end
            total++; if (lat != 5) begin bad++; $display("FAIL single_latency[%0d] got=%0d want=5", i, lat); end
            total++; if (out_data !== r_tab[i]) begin bad++; $display("FAIL single_data[%0d] got=%0d want=%0d", i, out_data, r_tab[i]); end
            total++; if (out_tag !== 4'(i + 3)) begin bad++; $display("FAIL single_tag[%0d] got=%0d want=%0d", i, out_tag, i + 3); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int n);
        int sent = 0, got = 0, cyc = 0, first_emit = -1, last_emit = 0;
        logic [11:0] ed;
        logic [3:0]  et;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = rand_c(); in_tag = 4'($urandom);
        while (got < n && cyc < n + BOUND) begin
            @(negedge clk); cyc++;
            if (sent < n) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL btb_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
            end
            if (in_valid && in_ready) begin exp_d.push_back(ref1(in_data)); exp_t.push_back(in_tag); sent++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL btb_extra got=%0d want=none", out_data); end
                else begin
                    ed = exp_d.pop_front(); et = exp_t.pop_front();
                    if (out_data !== ed || out_tag !== et) begin
                        bad++; $display("FAIL btb_data got=%0d/%0d want=%0d/%0d", out_data, out_tag, ed, et);
                    end
                end
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc; got++;
            end
            @(posedge clk); #1;
            if (sent < n) begin in_data = rand_c(); in_tag = 4'($urandom); end
            else in_valid = 1'b0;
        end
        total++; if (got != n) begin bad++; $display("FAIL btb_count got=%0d want=%0d", got, n); end
        total++; if (last_emit - first_emit != n - 1) begin bad++; $display("FAIL btb_rate got=%0d want=%0d", last_emit - first_emit, n - 1); end
    endtask

    task automatic test_stall(input int n);
        int sent = 0, got = 0, cyc = 0, occ;
        logic prev_hold = 1'b0, acc;
        logic [11:0] prev_d, ed;
        logic [3:0]  prev_t, et;
        in_valid = 1'b1; in_data = rand_c(); in_tag = 4'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        while (got < n && cyc < 4 * n + BOUND) begin
            @(negedge clk); cyc++;
            occ = exp_d.size();
            total++;
            if (in_ready !== !(occ == 5 && !out_ready)) begin
                bad++; $display("FAIL stall_in_ready occ=%0d got=%b want=%b", occ, in_ready, !(occ == 5 && !out_ready));
            end
            if (prev_hold) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
                    bad++; $display("FAIL stall_hold got=%b/%0d/%0d want=1/%0d/%0d", out_valid, out_data, out_tag, prev_d, prev_t);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin exp_d.push_back(ref1(in_data)); exp_t.push_back(in_tag); sent++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL stall_extra got=%0d want=none", out_data); end
                else begin
                    ed = exp_d.pop_front(); et = exp_t.pop_front();
                    if (out_data !== ed || out_tag !== et) begin
                        bad++; $display("FAIL stall_data got=%0d/%0d want=%0d/%0d", out_data, out_tag, ed, et);
                    end
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            prev_d = out_data; prev_t = out_tag;
            @(posedge clk); #1;
            if (acc) begin in_data = rand_c(); in_tag = 4'($urandom); end
            in_valid  = (sent < n);
            out_ready = (sent < n) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != n || exp_d.size() != 0) begin bad++; $display("FAIL stall_count got=%0d left=%0d want=%0d left=0", got, exp_d.size(), n); end
    endtask

    task automatic test_full_release();
        int acc_n = 0, guard = 0;
        logic [11:0] ed;
        logic [3:0]  et;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rand_c(); in_tag = 4'($urandom);
        @(negedge clk);
        while (in_ready === 1'b1 && guard < BOUND) begin
            exp_d.push_back(ref1(in_data)); exp_t.push_back(in_tag); acc_n++;
            @(posedge clk); #1 in_data = rand_c(); in_tag = 4'($urandom);
            @(negedge clk); guard++;
        end
        total++; if (acc_n != 5) begin bad++; $display("FAIL full_fill got=%0d want=5", acc_n); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_out_valid got=%b want=1", out_valid); end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        if (in_valid && in_ready) begin exp_d.push_back(ref1(in_data)); exp_t.push_back(in_tag); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || exp_d.size() == 0) begin
                bad++; $display("FAIL release_emit[%0d] got=%b want=1", i, out_valid);
            end else begin
                ed = exp_d.pop_front(); et = exp_t.pop_front();
                if (out_data !== ed || out_tag !== et) begin
                    bad++; $display("FAIL release_data[%0d] got=%0d/%0d want=%0d/%0d", i, out_data, out_tag, ed, et);
                end
            end
            if (i == 0) begin
                total++; if (exp_d.size() != 5) begin bad++; $display("FAIL release_occupancy got=%0d want=5", exp_d.size()); end
            end
            @(posedge clk); #1 in_valid = 1'b0;
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_drained got=%b want=0", out_valid); end
        exp_d.delete(); exp_t.delete();
    endtask

    task automatic test_reset_mid();
        int waited = 0, lat;
        logic [31:0] c;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 in_valid = 1'b1; in_data = rand_c(); in_tag = 4'(i);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        while (out_valid !== 1'b1 && waited < BOUND) begin @(negedge clk); waited++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_loaded got=%b want=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 12'd0) begin bad++; $display("FAIL rstmid_out_data got=%0d want=0", out_data); end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale[%0d] got=%b want=0", i, out_valid); end
        end
        @(posedge clk); #1;
        c = rand_c(); in_valid = 1'b1; in_data = c; in_tag = 4'd9;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < BOUND) begin @(negedge clk); lat++; end
        total++; if (lat != 5) begin bad++; $display("FAIL rstmid_latency got=%0d want=5", lat); end
        total++;
        if (out_data !== ref1(c) || out_tag !== 4'd9) begin
            bad++; $display("FAIL rstmid_data got=%0d/%0d want=%0d/9", out_data, out_tag, ref1(c));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alt_params(input int n);
        int sent = 0, got = 0, cyc = 0;
        logic acc;
        logic [12:0] ed;
        logic [3:0]  et;
        in_valid2 = 1'b1; in_data2 = rand_c(); in_tag2 = 4'($urandom);
        out_ready2 = 1'b1;
        while (got < n && cyc < 4 * n + BOUND) begin
            @(negedge clk); cyc++;
            acc = in_valid2 && in_ready2;
            if (acc) begin exp2_d.push_back(ref2(in_data2)); exp2_t.push_back(in_tag2); sent++; end
            if (out_valid2 && out_ready2) begin
                total++;
                if (exp2_d.size() == 0) begin bad++; $display("FAIL alt_extra got=%0d want=none", out_data2); end
                else begin
                    ed = exp2_d.pop_front(); et = exp2_t.pop_front();
                    if (out_data2 !== ed || out_tag2 !== et) begin
                        bad++; $display("FAIL alt_data got=%0d/%0d want=%0d/%0d", out_data2, out_tag2, ed, et);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin in_data2 = rand_c(); in_tag2 = 4'($urandom); end
            in_valid2  = (sent < n);
            out_ready2 = ($urandom_range(0, 3) != 0);
        end
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        total++; if (got != n) begin bad++; $display("FAIL alt_count got=%0d want=%0d", got, n); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_tag2 = '0; out_ready2 = 1'b1;
        test_reset();
        test_single();
        test_back_to_back(1000);
        test_stall(1000);
        test_full_release();
        test_reset_mid();
        test_alt_params(500);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
